// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front-end: ALU op encodings, funct3 codes, FSM states and decode bundle.
// The build macro ALU_ISSUE_MUL_EN enables the shift-add multiplier path.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_STEPS = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHL = 3'b001,
    ALU_SUB = 3'b010,
    ALU_XOR = 3'b100,
    ALU_SHR = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;

  typedef enum logic [1:0] {SEL_ALU, SEL_SLT, SEL_ULT} res_sel_t;

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_cond_t;

  typedef struct packed {
    alu_op_t  alu_op;
    res_sel_t res_sel;
    br_cond_t br_cond;
    logic     is_mul;
    logic     illegal;
  } dec_t;

  function automatic logic br_taken(br_cond_t cond, logic zero, logic slt, logic ult);
    case (cond)
      BR_EQ:   br_taken = zero;
      BR_NE:   br_taken = !zero;
      BR_LT:   br_taken = slt;
      BR_GE:   br_taken = !slt;
      BR_LTU:  br_taken = ult;
      BR_GEU:  br_taken = !ult;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request/response handshake bundle between decode and the ALU issue unit.
// master = decode/writeback side, slave = alu_issue_unit.
interface alu_issue_unit_if;
  import alu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_funct7b5;
  logic            req_funct7b0;
  logic            req_is_imm;
  logic            req_is_branch;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_taken;
  logic            rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_funct7b5, req_funct7b0, req_is_imm, req_is_branch,
           req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_funct7b5, req_funct7b0, req_is_imm, req_is_branch,
           req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );

endinterface

// File: rtl/alu_funct_decoder.sv
// Combinational RV32I funct3/funct7 decode into ALU op, result select, branch condition and illegal flag.
// With ALU_ISSUE_MUL_EN defined, register-register funct3=000 with funct7b0 selects the multiplier.
module alu_funct_decoder
  import alu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       is_imm,
  input  logic       is_branch,
  output dec_t       dec
);

  always_comb begin
    dec = '{alu_op: ALU_ADD, res_sel: SEL_ALU, br_cond: BR_NONE, is_mul: 1'b0, illegal: 1'b0};
    if (funct7b0) begin
`ifdef ALU_ISSUE_MUL_EN
      if (!is_imm && !is_branch && funct3 == F3_ADD) dec.is_mul = 1'b1;
      else                                           dec.illegal = 1'b1;
`else
      dec.illegal = 1'b1;
`endif
    end else if (is_branch) begin
      dec.alu_op = ALU_SUB;
      case (funct3)
        F3_BEQ:  dec.br_cond = BR_EQ;
        F3_BNE:  dec.br_cond = BR_NE;
        F3_BLT:  dec.br_cond = BR_LT;
        F3_BGE:  dec.br_cond = BR_GE;
        F3_BLTU: dec.br_cond = BR_LTU;
        F3_BGEU: dec.br_cond = BR_GEU;
        default: dec.illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_ADD:  dec.alu_op = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
        F3_SLL:  dec.alu_op = ALU_SHL;
        F3_SLT:  begin dec.alu_op = ALU_SUB; dec.res_sel = SEL_SLT; end
        F3_SLTU: begin dec.alu_op = ALU_SUB; dec.res_sel = SEL_ULT; end
        F3_XOR:  dec.alu_op = ALU_XOR;
        // the datapath shifter is logical only, so arithmetic right shift is rejected
        F3_SR:   if (funct7b5) dec.illegal = 1'b1;
                 else          dec.alu_op  = ALU_SHR;
        F3_OR:   dec.alu_op = ALU_OR;
        default: dec.alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue front-end: registers a decoded request, drives the external ALU, returns result/branch decision.
// Build macro ALU_ISSUE_MUL_EN adds a MUL_STEPS-cycle shift-add multiplier reusing the ALU adder.
//   state   | meaning
//   IDLE    | waiting for a request (req_ready high one cycle after reset release)
//   EXEC    | registered operands drive the ALU; result captured on exit
//   MUL     | one shift-add step per cycle using the ALU as accumulator adder
//   DONE    | rsp_valid raised on the first edge, response held until rsp_ready
module alu_issue_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_unit_if.slave bus,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Zero,
  input  logic            signflag
);

  state_t          state;
  logic            req_ready_q;
  logic [XLEN-1:0] a_q, b_q;
  alu_op_t         alu_op_q;
  res_sel_t        res_sel_q;
  br_cond_t        br_cond_q;
  logic            illegal_q;
  logic            rsp_valid_q, rsp_taken_q, rsp_illegal_q;
  logic [XLEN-1:0] rsp_result_q;

  dec_t            dec_in;
  logic            accept;
  logic            slt, ult;
  logic [XLEN-1:0] exec_result;
  logic            exec_taken;

`ifdef ALU_ISSUE_MUL_EN
  localparam int CNT_W = $clog2(MUL_STEPS);
  logic [XLEN-1:0]  acc_q, mcand_q, mplier_q, acc_nxt;
  logic [CNT_W-1:0] cnt_q;
  assign acc_nxt = mplier_q[0] ? ALUResult : acc_q;
`endif

  alu_funct_decoder u_dec (
    .funct3    (bus.req_funct3),
    .funct7b5  (bus.req_funct7b5),
    .funct7b0  (bus.req_funct7b0),
    .is_imm    (bus.req_is_imm),
    .is_branch (bus.req_is_branch),
    .dec       (dec_in)
  );

  assign accept = (state == ST_IDLE) && req_ready_q && bus.req_valid;

  // when signs differ the subtraction may overflow, so the operand sign decides
  assign slt = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? a_q[XLEN-1] : signflag;
  assign ult = (a_q[XLEN-1] ^ b_q[XLEN-1]) ? b_q[XLEN-1] : signflag;

  always_comb begin
    exec_result = ALUResult;
    exec_taken  = 1'b0;
    if (illegal_q) begin
      exec_result = '0;
    end else if (br_cond_q != BR_NONE) begin
      exec_taken = br_taken(br_cond_q, Zero, slt, ult);
    end else if (res_sel_q == SEL_SLT) begin
      exec_result = {{(XLEN-1){1'b0}}, slt};
    end else if (res_sel_q == SEL_ULT) begin
      exec_result = {{(XLEN-1){1'b0}}, ult};
    end
  end

  always_comb begin
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = ALU_ADD;
    if (state == ST_EXEC) begin
      SrcA       = a_q;
      SrcB       = b_q;
      ALUControl = alu_op_q;
    end
`ifdef ALU_ISSUE_MUL_EN
    else if (state == ST_MUL) begin
      SrcA       = acc_q;
      SrcB       = mcand_q;
      ALUControl = ALU_ADD;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      req_ready_q   <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      alu_op_q      <= ALU_ADD;
      res_sel_q     <= SEL_ALU;
      br_cond_q     <= BR_NONE;
      illegal_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
`ifdef ALU_ISSUE_MUL_EN
      acc_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      cnt_q         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_q <= !accept;
          if (accept) begin
            a_q       <= bus.req_a;
            b_q       <= bus.req_b;
            alu_op_q  <= dec_in.alu_op;
            res_sel_q <= dec_in.res_sel;
            br_cond_q <= dec_in.br_cond;
            illegal_q <= dec_in.illegal;
            state     <= dec_in.is_mul ? ST_MUL : ST_EXEC;
`ifdef ALU_ISSUE_MUL_EN
            acc_q     <= '0;
            mcand_q   <= bus.req_b;
            mplier_q  <= bus.req_a;
            cnt_q     <= CNT_W'(MUL_STEPS - 1);
`endif
          end
        end
        ST_EXEC: begin
          rsp_result_q  <= exec_result;
          rsp_taken_q   <= exec_taken;
          rsp_illegal_q <= illegal_q;
          state         <= ST_DONE;
        end
`ifdef ALU_ISSUE_MUL_EN
        ST_MUL: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            rsp_result_q  <= acc_nxt;
            rsp_taken_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            state         <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_taken   = rsp_taken_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU; honours ALU_ISSUE_MUL_EN for the multiplier cases.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] SrcA, SrcB, ALUResult;
  logic [2:0]  ALUControl;
  logic        Zero, signflag;

  always #5 clk = ~clk;

  alu_issue_unit_if bus ();

  alu_issue_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .signflag   (signflag)
  );

  always_comb begin
    case (ALUControl)
      3'b000:  ALUResult = SrcA + SrcB;
      3'b001:  ALUResult = SrcA << SrcB[4:0];
      3'b010:  ALUResult = SrcA - SrcB;
      3'b100:  ALUResult = SrcA ^ SrcB;
      3'b101:  ALUResult = SrcA >> SrcB[4:0];
      3'b110:  ALUResult = SrcA | SrcB;
      3'b111:  ALUResult = SrcA & SrcB;
      default: ALUResult = 32'h0;
    endcase
  end
  assign Zero     = (ALUResult == 32'h0);
  assign signflag = ALUResult[31];

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        f7b5, f7b0, imm, br;
    logic [31:0] a, b;
    logic        chk_ctrl;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        taken, ill;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_funct3    = v.f3;
    bus.req_funct7b5  = v.f7b5;
    bus.req_funct7b0  = v.f7b0;
    bus.req_is_imm    = v.imm;
    bus.req_is_branch = v.br;
    bus.req_a         = v.a;
    bus.req_b         = v.b;
    bus.req_valid     = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (v.chk_ctrl) chk({v.name, ".ctrl"}, {29'b0, ALUControl}, {29'b0, v.ctrl});
    chk({v.name, ".srca"}, SrcA, v.a);
    chk({v.name, ".srcb"}, SrcB, v.b);
    chk({v.name, ".busy"}, {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, ".valid_n1"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({v.name, ".srca_done"}, SrcA, 32'd0);
    @(posedge clk); #1;
    chk({v.name, ".valid_n2"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({v.name, ".result"}, bus.rsp_result, v.res);
    chk({v.name, ".taken"}, {31'b0, bus.rsp_taken}, {31'b0, v.taken});
    chk({v.name, ".illegal"}, {31'b0, bus.rsp_illegal}, {31'b0, v.ill});
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({v.name, ".valid_clr"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({v.name, ".ready_back"}, {31'b0, bus.req_ready}, 32'd1);
  endtask

`ifdef ALU_ISSUE_MUL_EN
  task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v = '{nm, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, a, b, 1'b1, 3'b000, exp, 1'b0, 1'b0};
    wait_ready();
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({nm, ".ctrl"}, {29'b0, ALUControl}, 32'd0);
    chk({nm, ".srca_acc0"}, SrcA, 32'd0);
    chk({nm, ".srcb_mcand"}, SrcB, b);
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk({nm, ".valid_n32"}, {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk({nm, ".valid_n33"}, {31'b0, bus.rsp_valid}, 32'd1);
    chk({nm, ".result"}, bus.rsp_result, exp);
    chk({nm, ".illegal"}, {31'b0, bus.rsp_illegal}, 32'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({nm, ".valid_clr"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //           name        f3      f7b5  f7b0  imm   br    a             b             cc    ctrl    res           tk    ill
    vecs.push_back('{"add",   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        1'b1, 3'b000, 32'd12,       1'b0, 1'b0});
    vecs.push_back('{"sub",   3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3,        32'd5,        1'b1, 3'b010, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{"addi",  3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 32'd3,        32'd5,        1'b1, 3'b000, 32'd8,        1'b0, 1'b0});
    vecs.push_back('{"sll",   3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1,        32'd4,        1'b1, 3'b001, 32'd16,       1'b0, 1'b0});
    vecs.push_back('{"srl",   3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd31,       1'b1, 3'b101, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"xor",   3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 1'b1, 3'b100, 32'h00000FF0, 1'b0, 1'b0});
    vecs.push_back('{"or",    3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000000F0, 32'h0000000F, 1'b1, 3'b110, 32'h000000FF, 1'b0, 1'b0});
    vecs.push_back('{"and",   3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, 3'b111, 32'h0F000F00, 1'b0, 1'b0});
    vecs.push_back('{"slt",   3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b010, 32'd0,        1'b0, 1'b0});
    vecs.push_back('{"sltu",  3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h80000000, 1'b1, 3'b010, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"slti",  3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        1'b1, 3'b010, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"sra",   3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'd4,        1'b0, 3'b000, 32'd0,        1'b0, 1'b1});
    vecs.push_back('{"blt",   3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd1,        1'b1, 3'b010, 32'h7FFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"bltu",  3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'd1,        1'b1, 3'b010, 32'h7FFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"beq",   3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'd9,        32'd9,        1'b1, 3'b010, 32'd0,        1'b1, 1'b0});
    vecs.push_back('{"bne",   3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 32'd9,        32'd9,        1'b1, 3'b010, 32'd0,        1'b0, 1'b0});
    vecs.push_back('{"bge",   3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3,        1'b1, 3'b010, 32'hFFFFFFFB, 1'b0, 1'b0});
    vecs.push_back('{"bgeu",  3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3,        1'b1, 3'b010, 32'hFFFFFFFB, 1'b1, 1'b0});
    vecs.push_back('{"br010", 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 32'd4,        32'd4,        1'b0, 3'b000, 32'd0,        1'b0, 1'b1});
    vecs.push_back('{"m_f3_1",3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 32'd7,        32'd6,        1'b0, 3'b000, 32'd0,        1'b0, 1'b1});
`ifndef ALU_ISSUE_MUL_EN
    vecs.push_back('{"mul_off",3'b000,1'b0, 1'b1, 1'b0, 1'b0, 32'd7,        32'd6,        1'b0, 3'b000, 32'd0,        1'b0, 1'b1});
`endif

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_funct3 = 3'b0; bus.req_funct7b5 = 1'b0; bus.req_funct7b0 = 1'b0;
    bus.req_is_imm = 1'b0; bus.req_is_branch = 1'b0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst.rsp_result", bus.rsp_result, 32'd0);
    chk("rst.srca", SrcA, 32'd0);
    chk("rst.ctrl", {29'b0, ALUControl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // backpressure: response held 5 cycles while a competing request is presented
    wait_ready();
    v = '{"bp", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd100, 32'd23, 1'b1, 3'b000, 32'd123, 1'b0, 1'b0};
    drive_req(v);
    @(posedge clk); #1;
    bus.req_a = 32'd1; bus.req_b = 32'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp.valid", {31'b0, bus.rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp.hold_result", bus.rsp_result, 32'd123);
      chk("bp.hold_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp.release", {31'b0, bus.rsp_valid}, 32'd0);
    chk("bp.ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp.no_new", {31'b0, bus.rsp_valid}, 32'd0);

    // rsp_ready already high when rsp_valid rises
    wait_ready();
    v = '{"sc", 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'hAAAA5555, 32'hFFFF0000, 1'b1, 3'b100, 32'h55555555, 1'b0, 1'b0};
    bus.rsp_ready = 1'b1;
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("sc.valid_n1", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("sc.valid_n2", {31'b0, bus.rsp_valid}, 32'd1);
    chk("sc.result", bus.rsp_result, 32'h55555555);
    @(posedge clk); #1;
    chk("sc.valid_n3", {31'b0, bus.rsp_valid}, 32'd0);
    chk("sc.ready_n3", {31'b0, bus.req_ready}, 32'd1);
    bus.rsp_ready = 1'b0;

    // reset asserted while in EXEC
    wait_ready();
    v = '{"rx", 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd40, 32'd2, 1'b1, 3'b000, 32'd42, 1'b0, 1'b0};
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rx.exec_srca", SrcA, 32'd40);
    #2 rst_n = 1'b0;
    #1;
    chk("rx.rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rx.rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rx.rst_srca", SrcA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rx.after_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rx.after_valid", {31'b0, bus.rsp_valid}, 32'd0);
    run_vec(vecs[0]);

`ifdef ALU_ISSUE_MUL_EN
    run_mul("mul7x6", 32'd7, 32'd6, 32'd42);
    run_mul("mulFx2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
